// File: rtl/foc_params_32x32_if.sv
// Host byte stream, datapath read port and optional readback stream for the FOC parameter bank.
interface foc_params_32x32_if;
    logic [4:0]  addr;
    logic [31:0] q;
    logic [7:0]  rx_d;
    logic        rx_dv;
    logic        busy;
    logic        wr_done;
    logic        err;
    logic [7:0]  tx_d;
    logic        tx_dv;
    logic        tx_rdy;

    modport slave (
        input  addr, rx_d, rx_dv, tx_rdy,
        output q, busy, wr_done, err, tx_d, tx_dv
    );

    modport master (
        output addr, rx_d, rx_dv, tx_rdy,
        input  q, busy, wr_done, err, tx_d, tx_dv
    );
endinterface

// File: rtl/foc_params_32x32.sv
// Writable 32x32 FOC parameter bank loaded from a host byte stream; entry 0x1f always reads 0.
// Optional byte readback over tx_d/tx_dv is enabled by defining FOC_PARAMS_READBACK_EN.
module foc_params_32x32 #(
    parameter int unsigned TIMEOUT   = 2048,
    parameter int unsigned TIMEOUT_W = 12
) (
    input logic               c,
    input logic               r,
    foc_params_32x32_if.slave bus
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 32;
    localparam logic [AW-1:0] ZERO_ADDR = 5'h1f;

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
`ifdef FOC_PARAMS_READBACK_EN
    localparam logic [1:0] ST_TX   = 2'd3;
`endif

    logic [DW-1:0]        mem [DEPTH];
    logic [1:0]           state, state_nxt;
    logic [AW-1:0]        clr_idx, clr_idx_nxt;
    logic [AW-1:0]        waddr, waddr_nxt;
    logic [1:0]           cnt, cnt_nxt;
    logic [23:0]          word, word_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;
    logic                 busy, busy_nxt;
    logic                 wr_done, wr_done_nxt;
    logic                 err, err_nxt;
    logic [DW-1:0]        q;
    logic                 we_c;
    logic [AW-1:0]        wa_c;
    logic [DW-1:0]        wd_c;
`ifdef FOC_PARAMS_READBACK_EN
    logic [DW-1:0]        tx_word, tx_word_nxt;
    logic [1:0]           tx_cnt, tx_cnt_nxt;
    logic [7:0]           tx_d, tx_d_nxt;
    logic                 tx_dv, tx_dv_nxt;
`endif

    // Next-state, write-port and output decode.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        waddr_nxt   = waddr;
        cnt_nxt     = cnt;
        word_nxt    = word;
        timer_nxt   = timer;
        busy_nxt    = 1'b0;
        wr_done_nxt = 1'b0;
        err_nxt     = 1'b0;
        we_c        = 1'b0;
        wa_c        = clr_idx;
        wd_c        = '0;
`ifdef FOC_PARAMS_READBACK_EN
        tx_word_nxt = tx_word;
        tx_cnt_nxt  = tx_cnt;
        tx_d_nxt    = tx_d;
        tx_dv_nxt   = tx_dv;
`endif
        case (state)
            ST_CLR: begin
                busy_nxt    = 1'b1;
                we_c        = 1'b1;
                wa_c        = clr_idx;
                clr_idx_nxt = clr_idx + AW'(1);
                if (clr_idx == ZERO_ADDR) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    if (bus.rx_d[7:5] == 3'b100) begin
                        waddr_nxt = bus.rx_d[4:0];
                        cnt_nxt   = 2'd0;
                        timer_nxt = '0;
                        state_nxt = ST_DATA;
                    end else if (bus.rx_d[7:5] == 3'b000) begin
`ifdef FOC_PARAMS_READBACK_EN
                        tx_word_nxt = (bus.rx_d[4:0] == ZERO_ADDR) ? '0 : mem[bus.rx_d[4:0]];
                        tx_cnt_nxt  = 2'd0;
                        tx_d_nxt    = tx_word_nxt[7:0];
                        tx_dv_nxt   = 1'b1;
                        state_nxt   = ST_TX;
`else
                        err_nxt = 1'b1;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_dv) begin
                    timer_nxt = '0;
                    cnt_nxt   = cnt + 2'd1;
                    case (cnt)
                        2'd0: word_nxt[7:0]   = bus.rx_d;
                        2'd1: word_nxt[15:8]  = bus.rx_d;
                        2'd2: word_nxt[23:16] = bus.rx_d;
                        default: begin
                            // Fourth byte completes the word; 0x1f is acknowledged but never stored.
                            we_c        = (waddr != ZERO_ADDR);
                            wa_c        = waddr;
                            wd_c        = {bus.rx_d, word};
                            wr_done_nxt = 1'b1;
                            state_nxt   = ST_IDLE;
                        end
                    endcase
                end else if (timer == TIMEOUT_W'(TIMEOUT)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer + TIMEOUT_W'(1);
                end
            end
`ifdef FOC_PARAMS_READBACK_EN
            ST_TX: begin
                if (tx_dv && bus.tx_rdy) begin
                    if (tx_cnt == 2'd3) begin
                        tx_dv_nxt = 1'b0;
                        state_nxt = ST_IDLE;
                    end else begin
                        tx_cnt_nxt = tx_cnt + 2'd1;
                        tx_d_nxt   = 8'(tx_word >> {tx_cnt_nxt, 3'b000});
                    end
                end
            end
`endif
            default: state_nxt = ST_CLR;
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            state   <= ST_CLR;
            clr_idx <= '0;
            waddr   <= '0;
            cnt     <= '0;
            word    <= '0;
            timer   <= '0;
            busy    <= 1'b1;
            wr_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            waddr   <= waddr_nxt;
            cnt     <= cnt_nxt;
            word    <= word_nxt;
            timer   <= timer_nxt;
            busy    <= busy_nxt;
            wr_done <= wr_done_nxt;
            err     <= err_nxt;
        end
    end

`ifdef FOC_PARAMS_READBACK_EN
    always_ff @(posedge c) begin
        if (r) begin
            tx_word <= '0;
            tx_cnt  <= '0;
            tx_d    <= '0;
            tx_dv   <= 1'b0;
        end else begin
            tx_word <= tx_word_nxt;
            tx_cnt  <= tx_cnt_nxt;
            tx_d    <= tx_d_nxt;
            tx_dv   <= tx_dv_nxt;
        end
    end

    assign bus.tx_d  = tx_d;
    assign bus.tx_dv = tx_dv;
`else
    assign bus.tx_d  = '0;
    assign bus.tx_dv = 1'b0;
`endif

    // Storage has no reset; the post-reset sweep clears it.
    always_ff @(posedge c) begin
        if (we_c && !r) begin
            mem[wa_c] <= wd_c;
        end
    end

    // Read sees pre-commit contents when a write lands the same cycle.
    always_ff @(posedge c) begin
        if (r) begin
            q <= '0;
        end else begin
            q <= (bus.addr == ZERO_ADDR) ? '0 : mem[bus.addr];
        end
    end

    assign bus.q       = q;
    assign bus.busy    = busy;
    assign bus.wr_done = wr_done;
    assign bus.err     = err;

endmodule

// File: tb/tb_foc_params_32x32.sv
// Directed bench for foc_params_32x32: clear sweep, frame writes, 0x1f, timeout, bad command, readback.
module tb_foc_params_32x32;

    localparam int unsigned TIMEOUT = 2048;

    logic c;
    logic r;
    int   checks;
    int   failures;
    int   err_cnt;
    int   wd_cnt;
    int   both_cnt;

    foc_params_32x32_if bus ();

    foc_params_32x32 #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(12)) dut (
        .c  (c),
        .r  (r),
        .bus(bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    always @(negedge c) begin
        if (bus.err === 1'b1) err_cnt++;
        if (bus.wr_done === 1'b1) wd_cnt++;
        if (bus.err === 1'b1 && bus.wr_done === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge c);
        bus.rx_d  = b;
        bus.rx_dv = 1'b1;
        @(negedge c);
        bus.rx_dv = 1'b0;
    endtask

    task automatic read_addr(input logic [4:0] a, output logic [31:0] v);
        bus.addr = a;
        @(negedge c);
        v = bus.q;
    endtask

    logic [31:0] v;
    int          base_e;
    int          base_w;
    int          bcnt;
    logic [7:0]  got [4];
    int          ngot;
    int          held_bad;
    logic        prev_pending;
    logic [7:0]  prev_d;

    initial begin
        checks = 0; failures = 0; err_cnt = 0; wd_cnt = 0; both_cnt = 0;
        r = 1'b1;
        bus.addr = 5'd5; bus.rx_d = '0; bus.rx_dv = 1'b0; bus.tx_rdy = 1'b0;
        repeat (3) @(negedge c);
        check("rst_q", bus.q, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h1);
        check("rst_wr_done", 32'(bus.wr_done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_tx_dv", 32'(bus.tx_dv), 32'h0);

        // Clear sweep length.
        r = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy !== 1'b1) break;
            bcnt++;
            @(posedge c); #1;
        end
        check("busy_cycles", 32'(bcnt), 32'd32);
        @(negedge c);
        for (int a = 0; a < 32; a++) begin
            read_addr(5'(a), v);
            check($sformatf("clr_q_%0d", a), v, 32'h0);
        end

        // 1.0f into entry 3.
        base_w = wd_cnt;
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80); send_byte(8'h3f);
        repeat (2) @(negedge c);
        check("wr3_pulses", 32'(wd_cnt - base_w), 32'd1);
        read_addr(5'd3, v);
        check("wr3_q", v, 32'h3f800000);

        // Entry 0x1f acknowledges but stays zero.
        base_w = wd_cnt;
        send_byte(8'h9f); send_byte(8'hef); send_byte(8'hbe); send_byte(8'had); send_byte(8'hde);
        repeat (2) @(negedge c);
        check("wr1f_pulses", 32'(wd_cnt - base_w), 32'd1);
        read_addr(5'h1f, v);
        check("wr1f_q", v, 32'h0);
        read_addr(5'd3, v);
        check("wr1f_keep3", v, 32'h3f800000);

        // Inter-byte timeout aborts the partial frame.
        base_e = err_cnt;
        base_w = wd_cnt;
        send_byte(8'h82); send_byte(8'h11);
        repeat (TIMEOUT - 5) @(negedge c);
        check("to_no_early_err", 32'(err_cnt - base_e), 32'd0);
        repeat (30) @(negedge c);
        check("to_err_pulses", 32'(err_cnt - base_e), 32'd1);
        check("to_no_wr_done", 32'(wd_cnt - base_w), 32'd0);
        read_addr(5'd2, v);
        check("to_mem2_kept", v, 32'h0);
        send_byte(8'h82); send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        repeat (2) @(negedge c);
        read_addr(5'd2, v);
        check("to_rewrite2", v, 32'h11223344);

        // Byte landing on the cycle the timer reaches TIMEOUT is still accepted.
        base_e = err_cnt;
        send_byte(8'h84); send_byte(8'haa);
        repeat (TIMEOUT - 1) @(negedge c);
        send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
        repeat (2) @(negedge c);
        check("edge_no_err", 32'(err_cnt - base_e), 32'd0);
        read_addr(5'd4, v);
        check("edge_q4", v, 32'hddccbbaa);

        // Malformed command.
        base_e = err_cnt;
        send_byte(8'h45);
        repeat (2) @(negedge c);
        check("bad_cmd_err", 32'(err_cnt - base_e), 32'd1);
        send_byte(8'h85); send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        repeat (2) @(negedge c);
        read_addr(5'd5, v);
        check("bad_cmd_then_wr5", v, 32'h01020304);

        send_byte(8'h87); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        repeat (2) @(negedge c);
        read_addr(5'd7, v);
        check("wr7_q", v, 32'h12345678);

`ifdef FOC_PARAMS_READBACK_EN
        // Readback with tx_rdy toggling every other cycle.
        send_byte(8'h07);
        ngot = 0; held_bad = 0; prev_pending = 1'b0; prev_d = '0;
        for (int k = 0; k < 60 && ngot < 4; k++) begin
            if (prev_pending && (bus.tx_dv !== 1'b1 || bus.tx_d !== prev_d)) held_bad++;
            bus.tx_rdy = k[0];
            prev_pending = 1'b0;
            if (bus.tx_dv === 1'b1) begin
                if (bus.tx_rdy) begin
                    got[ngot] = bus.tx_d;
                    ngot++;
                end else begin
                    prev_pending = 1'b1;
                    prev_d = bus.tx_d;
                end
            end
            @(negedge c);
        end
        bus.tx_rdy = 1'b0;
        check("rb_count", 32'(ngot), 32'd4);
        check("rb_b0", 32'(got[0]), 32'h78);
        check("rb_b1", 32'(got[1]), 32'h56);
        check("rb_b2", 32'(got[2]), 32'h34);
        check("rb_b3", 32'(got[3]), 32'h12);
        check("rb_held", 32'(held_bad), 32'd0);
        @(negedge c);
        check("rb_tx_dv_low", 32'(bus.tx_dv), 32'h0);
`else
        base_e = err_cnt;
        send_byte(8'h07);
        repeat (2) @(negedge c);
        check("rb_disabled_err", 32'(err_cnt - base_e), 32'd1);
        check("rb_disabled_tx_dv", 32'(bus.tx_dv), 32'h0);
`endif

        check("err_wr_done_exclusive", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
